// File: rtl/ft245_tx_arbiter_pkg.sv
// rtl/ft245_tx_arbiter_pkg.sv - shared header magic, FSM encodings and optional-header switch (FT245_TX_HDR_EN)
`ifndef FT245_HDR_MAGIC
`define FT245_HDR_MAGIC 8'hA0
`endif
// FT245_TX_HDR_EN is left undefined by default: raw source bytes, no header state.

package ft245_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HDR    = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

endpackage

// File: rtl/ft245_tx_arbiter_rr_pick.sv
// rtl/ft245_tx_arbiter_rr_pick.sv - combinational round-robin picker: first set request at or after ptr
module ft245_tx_arbiter_rr_pick #(
    parameter int NUM_SRC  = 4,
    parameter int SRC_ID_W = 2
) (
    input  logic [NUM_SRC-1:0]  req,
    input  logic [SRC_ID_W-1:0] ptr,
    output logic                valid,
    output logic [SRC_ID_W-1:0] idx
);

    logic [SRC_ID_W:0]   sum;
    logic [SRC_ID_W-1:0] cand;

    // Scan offsets from far to near so the request closest to ptr wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        sum   = '0;
        cand  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            sum = {1'b0, ptr} + (SRC_ID_W + 1)'(i);
            if (sum >= (SRC_ID_W + 1)'(NUM_SRC)) begin
                sum = sum - (SRC_ID_W + 1)'(NUM_SRC);
            end
            cand = sum[SRC_ID_W-1:0];
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/ft245_tx_arbiter.sv
// rtl/ft245_tx_arbiter.sv - packet-granular round-robin arbiter onto the FT245 TX channel (FT245_TX_HDR_EN adds a header byte)
module ft245_tx_arbiter
    import ft245_tx_arbiter_pkg::*;
#(
    parameter int NUM_SRC      = 4,
    parameter int FT245_WIDTH  = 8,
    parameter int SRC_ID_W     = 2,
    parameter int IDLE_TIMEOUT = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_SRC*FT245_WIDTH-1:0] src_data_si,
    input  logic [NUM_SRC-1:0]             src_rdy_si,
    input  logic [NUM_SRC-1:0]             src_last_si,
    output logic [NUM_SRC-1:0]             src_ack_si,
    output logic [FT245_WIDTH-1:0]         tx_data_si,
    output logic                           tx_rdy_si,
    input  logic                           tx_ack_si,
    output logic [SRC_ID_W-1:0]            grant_id,
    output logic                           busy
);

    localparam int STALL_W = (IDLE_TIMEOUT < 1) ? 1 : $clog2(IDLE_TIMEOUT + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(IDLE_TIMEOUT - 1);
    localparam logic [STALL_W-1:0] STALL_MAX  = '1;

    state_t                  state;
    logic [SRC_ID_W-1:0]     rr_ptr;
    logic [STALL_W-1:0]      stall_cnt;
    logic                    pick_valid;
    logic [SRC_ID_W-1:0]     pick_idx;
    logic                    g_rdy;
    logic                    g_last;
    logic [FT245_WIDTH-1:0]  g_data;
    logic [SRC_ID_W-1:0]     next_ptr;

    ft245_tx_arbiter_rr_pick #(
        .NUM_SRC  (NUM_SRC),
        .SRC_ID_W (SRC_ID_W)
    ) u_rr_pick (
        .req   (src_rdy_si),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign g_rdy    = src_rdy_si[grant_id];
    assign g_last   = src_last_si[grant_id];
    assign g_data   = src_data_si[grant_id*FT245_WIDTH +: FT245_WIDTH];
    assign next_ptr = (grant_id == SRC_ID_W'(NUM_SRC - 1)) ? '0 : grant_id + 1'b1;

    always_comb begin
        tx_data_si = '0;
        tx_rdy_si  = 1'b0;
        src_ack_si = '0;
        case (state)
            ST_STREAM: begin
                tx_data_si           = g_data;
                tx_rdy_si            = g_rdy;
                src_ack_si[grant_id] = tx_ack_si & g_rdy;
            end
`ifdef FT245_TX_HDR_EN
            ST_HDR: begin
                tx_rdy_si  = 1'b1;
                tx_data_si = FT245_WIDTH'(`FT245_HDR_MAGIC) | FT245_WIDTH'(grant_id);
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            stall_cnt <= '0;
            grant_id  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    stall_cnt <= '0;
                    if (pick_valid) begin
                        grant_id <= pick_idx;
                        busy     <= 1'b1;
`ifdef FT245_TX_HDR_EN
                        state    <= ST_HDR;
`else
                        state    <= ST_STREAM;
`endif
                    end
                end
                ST_HDR: begin
                    if (tx_ack_si) begin
                        state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (g_rdy) begin
                        stall_cnt <= '0;
                        if (tx_ack_si && g_last) begin
                            state  <= ST_IDLE;
                            busy   <= 1'b0;
                            rr_ptr <= next_ptr;
                        end
                    end else if (IDLE_TIMEOUT != 0 && stall_cnt == STALL_LAST) begin
                        // Source went quiet mid-packet: abandon it and move on.
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        rr_ptr    <= next_ptr;
                        stall_cnt <= '0;
                    end else if (stall_cnt != STALL_MAX) begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
